car_dispatch_responder: RTL and testbench

// Car-side responder to the central dispatcher. Latches hall calls assigned to this car and

---
 rtl/elevator_pkg.sv | 25 ++
 rtl/cycle_timer.sv | 35 +++
 rtl/car_dispatch_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_car_dispatch_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared encodings and state type for the car-side elevator controller.
package elevator_pkg;

  localparam int NFLOOR_DEF = 10;

  localparam logic [1:0] MOTOR_STOP = 2'b00;
  localparam logic [1:0] MOTOR_UP   = 2'b01;
  localparam logic [1:0] MOTOR_DOWN = 2'b10;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN
  } car_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Down-counting cycle timer: load arms it, done flags the last enabled cycle.
module cycle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         enable,
  output logic         done
);

  logic [W-1:0] count_q, count_d;

  assign done = enable && (count_q <= W'(1));

  // Load wins over counting so a caller can re-arm on the same edge it sees done.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (enable && (count_q > W'(1))) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/car_dispatch_responder.sv
// Car-side responder: latches assigned/car calls, runs a SCAN sequence between floors,
// drives motor and door, and pulses the floor whose calls were just served.
module car_dispatch_responder
  import elevator_pkg::*;
#(
  parameter int  NFLOOR     = NFLOOR_DEF,
  parameter int  TRAVEL_CYC = 4,
  parameter int  DOOR_CYC   = 3,
  localparam int FLOOR_W    = $clog2(NFLOOR + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NFLOOR:0]    floor_assign,
  input  logic [NFLOOR:0]    req_in_lift,
  output logic [1:0]         motor_signal,
  output logic [FLOOR_W-1:0] lift_state,
  output logic [1:0]         car_dir,
  output logic               door_open,
  output logic [NFLOOR:0]    serviced,
  output logic               busy
);

  localparam int TW = $clog2(max_int(TRAVEL_CYC, DOOR_CYC) + 1);

  car_state_t         state_q, state_d;
  logic [NFLOOR:0]    pending_q, pending_d, pending_set, pending_clr;
  logic [FLOOR_W-1:0] lift_state_q, lift_state_d, up_floor, dn_floor;
  logic [1:0]         motor_q, motor_d, car_dir_q, car_dir_d;
  logic               door_q, door_d, busy_q, busy_d;
  logic [NFLOOR:0]    serviced_q, serviced_d;

  logic [NFLOOR:0]    above_cur, below_cur, above_up, below_dn;
  logic               has_above, has_below, near_valid, near_up;
  logic               leave_up, leave_dn, cur_req;
  int                 up_pos, dn_pos;
  logic               trav_load, trav_en, trav_done;
  logic               dwell_load, dwell_en, dwell_done;

  assign up_floor = (int'(lift_state_q) < NFLOOR) ? lift_state_q + FLOOR_W'(1) : lift_state_q;
  assign dn_floor = (lift_state_q != '0) ? lift_state_q - FLOOR_W'(1) : lift_state_q;

  for (genvar gi = 0; gi <= NFLOOR; gi++) begin : g_mask
    assign above_cur[gi] = pending_q[gi] && (gi > int'(lift_state_q));
    assign below_cur[gi] = pending_q[gi] && (gi < int'(lift_state_q));
    assign above_up[gi]  = pending_q[gi] && (gi > int'(up_floor));
    assign below_dn[gi]  = pending_q[gi] && (gi < int'(dn_floor));
  end

  assign has_above  = |above_cur;
  assign has_below  = |below_cur;
  assign near_valid = has_above || has_below;

  // Nearest call above is the lowest set bit above cur; nearest below the highest below.
  always_comb begin
    up_pos  = NFLOOR;
    dn_pos  = 0;
    near_up = 1'b0;
    for (int f = NFLOOR; f >= 0; f--) begin
      if (above_cur[f]) up_pos = f;
    end
    for (int f = 0; f <= NFLOOR; f++) begin
      if (below_cur[f]) dn_pos = f;
    end
    if (has_above) begin
      near_up = !has_below ||
                ((up_pos - int'(lift_state_q)) <= (int'(lift_state_q) - dn_pos));
    end
  end

  always_comb begin
    leave_up = 1'b0;
    leave_dn = 1'b0;
    case (car_dir_q)
      DIR_UP: begin
        leave_up = has_above;
        leave_dn = !has_above && has_below;
      end
      DIR_DOWN: begin
        leave_dn = has_below;
        leave_up = !has_below && has_above;
      end
      default: begin
        leave_up = near_valid && near_up;
        leave_dn = near_valid && !near_up;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    lift_state_d = lift_state_q;
    car_dir_d    = car_dir_q;
    serviced_d   = '0;
    pending_clr  = '0;
    pending_set  = floor_assign | req_in_lift;
    trav_load    = 1'b0;
    dwell_load   = 1'b0;
    cur_req      = floor_assign[lift_state_q] | req_in_lift[lift_state_q];
    case (state_q)
      IDLE: begin
        car_dir_d = DIR_NONE;
        if (pending_q[lift_state_q]) begin
          state_d                   = DOOR_OPEN;
          dwell_load                = 1'b1;
          pending_clr[lift_state_q] = 1'b1;
          serviced_d[lift_state_q]  = 1'b1;
        end else if (near_valid) begin
          trav_load = 1'b1;
          state_d   = near_up ? MOVE_UP : MOVE_DOWN;
          car_dir_d = near_up ? DIR_UP : DIR_DOWN;
        end
      end
      MOVE_UP: begin
        if (trav_done) begin
          lift_state_d = up_floor;
          if (pending_q[up_floor]) begin
            state_d               = DOOR_OPEN;
            dwell_load            = 1'b1;
            pending_clr[up_floor] = 1'b1;
            serviced_d[up_floor]  = 1'b1;
          end else if (|above_up) begin
            trav_load = 1'b1;
          end else begin
            state_d   = IDLE;
            car_dir_d = DIR_NONE;
          end
        end
      end
      MOVE_DOWN: begin
        if (trav_done) begin
          lift_state_d = dn_floor;
          if (pending_q[dn_floor]) begin
            state_d               = DOOR_OPEN;
            dwell_load            = 1'b1;
            pending_clr[dn_floor] = 1'b1;
            serviced_d[dn_floor]  = 1'b1;
          end else if (|below_dn) begin
            trav_load = 1'b1;
          end else begin
            state_d   = IDLE;
            car_dir_d = DIR_NONE;
          end
        end
      end
      DOOR_OPEN: begin
        // A call for the open floor is answered on the spot and never latched.
        pending_set[lift_state_q] = 1'b0;
        if (cur_req) begin
          serviced_d[lift_state_q] = 1'b1;
          dwell_load               = 1'b1;
        end else if (dwell_done) begin
          if (leave_up) begin
            state_d   = MOVE_UP;
            car_dir_d = DIR_UP;
            trav_load = 1'b1;
          end else if (leave_dn) begin
            state_d   = MOVE_DOWN;
            car_dir_d = DIR_DOWN;
            trav_load = 1'b1;
          end else begin
            state_d   = IDLE;
            car_dir_d = DIR_NONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pending_d = (pending_q & ~pending_clr) | pending_set;
  assign door_d    = (state_d == DOOR_OPEN);
  assign busy_d    = (|pending_d) || (state_d != IDLE);
  assign trav_en   = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
  assign dwell_en  = (state_q == DOOR_OPEN);

  always_comb begin
    motor_d = MOTOR_STOP;
    if (state_d == MOVE_UP)   motor_d = MOTOR_UP;
    if (state_d == MOVE_DOWN) motor_d = MOTOR_DOWN;
  end

  cycle_timer #(.W(TW)) u_travel (
    .clk      (clk),
    .rst      (rst),
    .load     (trav_load),
    .load_val (TW'(TRAVEL_CYC)),
    .enable   (trav_en),
    .done     (trav_done)
  );

  cycle_timer #(.W(TW)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (dwell_load),
    .load_val (TW'(DOOR_CYC)),
    .enable   (dwell_en),
    .done     (dwell_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      lift_state_q <= '0;
      motor_q      <= MOTOR_STOP;
      car_dir_q    <= DIR_NONE;
      door_q       <= 1'b0;
      serviced_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      lift_state_q <= lift_state_d;
      motor_q      <= motor_d;
      car_dir_q    <= car_dir_d;
      door_q       <= door_d;
      serviced_q   <= serviced_d;
      busy_q       <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(state_q == MOVE_UP && int'(lift_state_q) >= NFLOOR));
      assert (!(state_q == MOVE_DOWN && lift_state_q == '0));
      assert (!(motor_q == MOTOR_UP && motor_d == MOTOR_DOWN));
      assert (!(motor_q == MOTOR_DOWN && motor_d == MOTOR_UP));
    end
  end

  assign motor_signal = motor_q;
  assign lift_state   = lift_state_q;
  assign car_dir      = car_dir_q;
  assign door_open    = door_q;
  assign serviced     = serviced_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_car_dispatch_responder.sv
// Directed bench for car_dispatch_responder at NFLOOR=10, TRAVEL_CYC=4, DOOR_CYC=3.
module tb_car_dispatch_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] floor_assign, req_in_lift;
  logic [1:0]  motor_signal, car_dir;
  logic [3:0]  lift_state;
  logic        door_open, busy;
  logic [10:0] serviced;

  int n_checks = 0;
  int n_pass   = 0;
  logic saw_up;

  car_dispatch_responder #(
    .NFLOOR     (10),
    .TRAVEL_CYC (4),
    .DOOR_CYC   (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .floor_assign (floor_assign),
    .req_in_lift  (req_in_lift),
    .motor_signal (motor_signal),
    .lift_state   (lift_state),
    .car_dir      (car_dir),
    .door_open    (door_open),
    .serviced     (serviced),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %s: got 0x%0h expected 0x%0h ok", tag, got, exp);
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_serviced(input logic [10:0] exp, input string tag);
    for (int i = 0; i < 120; i++) begin
      tick();
      if (serviced != '0) break;
    end
    check(tag, 32'(serviced), 32'(exp));
  endtask

  task automatic wait_floor(input logic [3:0] f, input string tag);
    for (int i = 0; i < 120; i++) begin
      tick();
      if (lift_state == f) break;
    end
    check(tag, 32'(lift_state), 32'(f));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_motor"}, 32'(motor_signal), 32'd0);
    check({tag, "_floor"}, 32'(lift_state), 32'd0);
    check({tag, "_dir"}, 32'(car_dir), 32'd0);
    check({tag, "_door"}, 32'(door_open), 32'd0);
    check({tag, "_svc"}, 32'(serviced), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset with random inputs, then release with no requests.
    rst = 1'b0;
    floor_assign = 11'($urandom);
    req_in_lift  = 11'($urandom);
    ticks(2);
    check_all_zero("t1_reset");
    rst = 1'b1;
    floor_assign = '0;
    req_in_lift  = '0;
    ticks(3);
    check_all_zero("t1_release");

    // Single call to floor 3.
    floor_assign = 11'h008;
    tick();
    floor_assign = '0;
    check("t2_busy_e1", 32'(busy), 32'd1);
    check("t2_motor_e1", 32'(motor_signal), 32'd0);
    tick();
    check("t2_motor_e2", 32'(motor_signal), 32'd1);
    check("t2_dir_e2", 32'(car_dir), 32'd1);
    ticks(3);
    check("t2_floor_e5", 32'(lift_state), 32'd0);
    tick();
    check("t2_floor_e6", 32'(lift_state), 32'd1);
    ticks(4);
    check("t2_floor_e10", 32'(lift_state), 32'd2);
    ticks(4);
    check("t2_floor_e14", 32'(lift_state), 32'd3);
    check("t2_motor_e14", 32'(motor_signal), 32'd0);
    check("t2_door_e14", 32'(door_open), 32'd1);
    check("t2_svc_e14", 32'(serviced), 32'h008);
    tick();
    check("t2_svc_e15", 32'(serviced), 32'd0);
    check("t2_door_e15", 32'(door_open), 32'd1);
    tick();
    check("t2_door_e16", 32'(door_open), 32'd1);
    tick();
    check("t2_door_e17", 32'(door_open), 32'd0);
    check("t2_busy_e17", 32'(busy), 32'd0);
    check("t2_dir_e17", 32'(car_dir), 32'd0);

    // SCAN order: {7,9} from floor 3, then 2 while passing 5 upward.
    floor_assign = 11'h280;
    tick();
    floor_assign = '0;
    wait_floor(4'd5, "t3_at5");
    check("t3_motor_at5", 32'(motor_signal), 32'd1);
    floor_assign = 11'h004;
    tick();
    floor_assign = '0;
    wait_serviced(11'h080, "t3_svc7");
    check("t3_floor7", 32'(lift_state), 32'd7);
    check("t3_dir7", 32'(car_dir), 32'd1);
    ticks(3);
    check("t3_cont_up", 32'(motor_signal), 32'd1);
    wait_serviced(11'h200, "t3_svc9");
    check("t3_floor9", 32'(lift_state), 32'd9);
    ticks(3);
    check("t3_rev_motor", 32'(motor_signal), 32'd2);
    check("t3_rev_dir", 32'(car_dir), 32'd2);
    wait_serviced(11'h004, "t3_svc2");
    check("t3_floor2", 32'(lift_state), 32'd2);
    ticks(3);
    check("t3_idle_busy", 32'(busy), 32'd0);

    // Door extension at floor 4: repeat press on dwell cycle 2.
    req_in_lift = 11'h010;
    tick();
    req_in_lift = '0;
    wait_serviced(11'h010, "t4_svc4");
    check("t4_door_e0", 32'(door_open), 32'd1);
    tick();
    check("t4_svc_e1", 32'(serviced), 32'd0);
    req_in_lift = 11'h010;
    tick();
    req_in_lift = '0;
    check("t4_second_pulse", 32'(serviced), 32'h010);
    check("t4_door_e2", 32'(door_open), 32'd1);
    ticks(2);
    check("t4_door_e4", 32'(door_open), 32'd1);
    tick();
    check("t4_door_e5", 32'(door_open), 32'd0);
    check("t4_busy_e5", 32'(busy), 32'd0);
    ticks(3);
    check("t4_no_reopen", 32'(door_open), 32'd0);

    // Tie from floor 5 with {3,7}: up first.
    floor_assign = 11'h020;
    tick();
    floor_assign = '0;
    wait_serviced(11'h020, "t5_svc5");
    ticks(3);
    check("t5_idle5", 32'(busy), 32'd0);
    floor_assign = 11'h088;
    tick();
    floor_assign = '0;
    tick();
    check("t5_tie_motor", 32'(motor_signal), 32'd1);
    check("t5_tie_dir", 32'(car_dir), 32'd1);
    wait_serviced(11'h080, "t5_svc7");
    wait_serviced(11'h008, "t5_svc3");

    // Top floor boundary.
    floor_assign = 11'h400;
    tick();
    floor_assign = '0;
    wait_serviced(11'h400, "t5_svc10");
    check("t5_floor10", 32'(lift_state), 32'd10);
    ticks(3);
    check("t5_idle10", 32'(busy), 32'd0);
    floor_assign = 11'h400;
    saw_up = 1'b0;
    tick();
    floor_assign = '0;
    check("t5_top_door_e1", 32'(door_open), 32'd0);
    tick();
    check("t5_top_door_e2", 32'(door_open), 32'd1);
    check("t5_top_svc_e2", 32'(serviced), 32'h400);
    for (int i = 0; i < 8; i++) begin
      if (motor_signal == 2'b01) saw_up = 1'b1;
      tick();
    end
    check("t5_top_no_up", 32'(saw_up), 32'd0);
    check("t5_top_busy", 32'(busy), 32'd0);

    // Reset while moving up between floors 6 and 7.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("t6_pre_floor", 32'(lift_state), 32'd0);
    floor_assign = 11'h100;
    tick();
    floor_assign = '0;
    wait_floor(4'd6, "t6_at6");
    ticks(2);
    check("t6_moving", 32'(motor_signal), 32'd1);
    rst = 1'b0;
    tick();
    check_all_zero("t6_reset");
    rst = 1'b1;
    ticks(4);
    check("t6_pending_gone", 32'(busy), 32'd0);
    check("t6_stay_stopped", 32'(motor_signal), 32'd0);
    check("t6_stay_floor0", 32'(lift_state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
